// File: rtl/arcade_dial.sv
// arcade_dial: multi-channel dial/spinner emulator with binary, Gray and quadrature-tracked outputs.
// Define DIAL_ACCEL_EN to enable hold acceleration. Without it, every step is 1.
module arcade_dial #(
    parameter int CHANNELS     = 2,
    parameter int WIDTH        = 7,
    parameter int STEP_MAX     = 4,
    parameter int ACCEL_FRAMES = 8,
    parameter int PHASE_DIV    = 64
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      strobe,
    input  logic [CHANNELS-1:0]       btn_left,
    input  logic [CHANNELS-1:0]       btn_right,
    input  logic [1:0]                mode,
    output logic [CHANNELS*WIDTH-1:0] dial_out,
    output logic [CHANNELS-1:0]       quad_a,
    output logic [CHANNELS-1:0]       quad_b,
    output logic [CHANNELS-1:0]       moving
);

    if (WIDTH < 2 || STEP_MAX < 1 || STEP_MAX > (1 << WIDTH) - 1 ||
        ACCEL_FRAMES < 1 || PHASE_DIV < 2) begin : g_param_check
        $error("arcade_dial: invalid parameter set");
    end

    localparam int PW = $clog2(PHASE_DIV);
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, MOVE} state_t;

    state_t                   state_q [CHANNELS];
    logic [WIDTH-1:0]         pos_q   [CHANNELS];
    logic [WIDTH-1:0]         phase_q [CHANNELS];
    logic [CHANNELS-1:0]      dir_q;
    logic [PW-1:0]            pdiv_q;
    logic                     strobe_q;
    logic [CHANNELS*WIDTH-1:0] dial_q;

    logic                     frame_edge;
    logic                     pdiv_wrap;
    logic [CHANNELS-1:0]      one_btn;
    logic [WIDTH-1:0]         step_d  [CHANNELS];
    logic [WIDTH-1:0]         phase_d [CHANNELS];
    logic [WIDTH-1:0]         diff_w  [CHANNELS];
    logic [WIDTH-1:0]         gray_w  [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] dial_d;

`ifdef DIAL_ACCEL_EN
    localparam int HMAX = STEP_MAX * ACCEL_FRAMES;
    localparam int HW   = $clog2(HMAX + 1);

    logic [HW-1:0] held_q [CHANNELS];
    logic [HW-1:0] held_d [CHANNELS];

    function automatic logic [WIDTH-1:0] step_of(input logic [HW-1:0] n);
        int unsigned s;
        s = 1 + (32'(n) - 1) / ACCEL_FRAMES;
        if (s > STEP_MAX) s = STEP_MAX;
        return s[WIDTH-1:0];
    endfunction
`endif

    assign frame_edge = strobe && !strobe_q;
    assign pdiv_wrap  = (pdiv_q == PW'(PHASE_DIV - 1));

    always_comb begin
        dial_d = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            one_btn[c] = btn_left[c] ^ btn_right[c];
`ifdef DIAL_ACCEL_EN
            // A reversal restarts the hold count so the first reversed step is 1.
            if (!one_btn[c])
                held_d[c] = '0;
            else if (state_q[c] == MOVE && btn_right[c] != dir_q[c])
                held_d[c] = HW'(1);
            else if (held_q[c] == HW'(HMAX))
                held_d[c] = held_q[c];
            else
                held_d[c] = held_q[c] + HW'(1);
            step_d[c] = step_of(held_d[c]);
`else
            step_d[c] = WIDTH'(1);
`endif
            // Shorter modular path: up when the upward distance is at most half the ring.
            diff_w[c]  = pos_q[c] - phase_q[c];
            phase_d[c] = phase_q[c];
            if (pdiv_wrap && diff_w[c] != '0)
                phase_d[c] = (diff_w[c] <= HALF) ? phase_q[c] + WIDTH'(1)
                                                 : phase_q[c] - WIDTH'(1);

            gray_w[c] = phase_q[c] ^ (phase_q[c] >> 1);
            quad_a[c] = gray_w[c][1];
            quad_b[c] = gray_w[c][0];
            moving[c] = (phase_q[c] != pos_q[c]);

            case (mode)
                2'b01:   dial_d[c*WIDTH +: WIDTH] = pos_q[c] ^ (pos_q[c] >> 1);
                2'b10:   dial_d[c*WIDTH +: WIDTH] = phase_q[c];
                default: dial_d[c*WIDTH +: WIDTH] = pos_q[c];
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            strobe_q <= 1'b0;
            pdiv_q   <= '0;
            dial_q   <= '0;
            dir_q    <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                state_q[c] <= IDLE;
                pos_q[c]   <= '0;
                phase_q[c] <= '0;
`ifdef DIAL_ACCEL_EN
                held_q[c]  <= '0;
`endif
            end
        end else begin
            strobe_q <= strobe;
            pdiv_q   <= pdiv_wrap ? '0 : pdiv_q + PW'(1);
            dial_q   <= dial_d;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                phase_q[c] <= phase_d[c];
                if (frame_edge) begin
`ifdef DIAL_ACCEL_EN
                    held_q[c] <= held_d[c];
`endif
                    if (one_btn[c]) begin
                        state_q[c] <= MOVE;
                        dir_q[c]   <= btn_right[c];
                        pos_q[c]   <= btn_right[c] ? pos_q[c] + step_d[c]
                                                   : pos_q[c] - step_d[c];
                    end else begin
                        state_q[c] <= IDLE;
                    end
                end
            end
        end
    end

    assign dial_out = dial_q;

endmodule

// File: tb/tb_arcade_dial.sv
// Scoreboard bench for arcade_dial: stimulus queues expected outputs, a negedge monitor checks them.
module tb_arcade_dial;

    localparam int CH = 2;
    localparam int W  = 7;
    localparam int PD = 64;
`ifdef DIAL_ACCEL_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset, strobe;
    logic [CH-1:0]   bl, br;
    logic [1:0]      mode;
    logic [CH*W-1:0] dial;
    logic [CH-1:0]   qa, qb, mv;

    arcade_dial #(.CHANNELS(CH), .WIDTH(W), .STEP_MAX(4), .ACCEL_FRAMES(8), .PHASE_DIV(PD)) dut (
        .clk_sys(clk), .reset(reset), .strobe(strobe), .btn_left(bl), .btn_right(br),
        .mode(mode), .dial_out(dial), .quad_a(qa), .quad_b(qb), .moving(mv)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    ch;
        int    kind;   // 0 dial, 1 quad {A,B}, 2 moving
        int    val;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic want(input string name, input int ch, input int kind, input int val);
        sb.push_back('{name, ch, kind, val});
    endtask

    task automatic want_zero(input string tag);
        for (int c = 0; c < CH; c++) begin
            want($sformatf("%s_dial%0d", tag, c), c, 0, 0);
            want($sformatf("%s_quad%0d", tag, c), c, 1, 0);
            want($sformatf("%s_mov%0d", tag, c), c, 2, 0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_t e;
                int   act;
                e = sb.pop_front();
                case (e.kind)
                    0:       act = int'(dial[e.ch*W +: W]);
                    1:       act = int'({qa[e.ch], qb[e.ch]});
                    default: act = int'(mv[e.ch]);
                endcase
                chk(e.name, act, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    // One isolated step: press for a single edge, then an idle edge.
    task automatic step_once(input int ch, input bit right);
        br[ch] = right;
        bl[ch] = !right;
        frame();
        br[ch] = 1'b0;
        bl[ch] = 1'b0;
        frame();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] prev;
        int         n;
        reset = 1'b1; strobe = 1'b0; bl = '0; br = '0; mode = 2'b00;

        // Reset with strobe toggling and buttons held
        tick();
        for (int i = 0; i < 6; i++) begin
            strobe = ~strobe;
            br     = '1;
            bl     = (i % 2 == 1) ? 2'b01 : 2'b00;
            tick();
            want_zero($sformatf("rst%0d", i));
        end
        strobe = 1'b0; br = '0; bl = '0;
        tick();
        reset = 1'b0;
        tick();
        want_zero("post_rst");

        // Right x3 then left x4 with wrap, channel 0
        br = 2'b01;
        frames(3);
        want("right3", 0, 0, 3);
        want("ch1_idle", 1, 0, 0);
        br = 2'b00; bl = 2'b01;
        frames(3);
        want("left3_zero", 0, 0, 0);
        frame();
        want("left4_wrap", 0, 0, 127);
        bl = 2'b00;
        frame();

        // Hold acceleration on channel 1, then reversal
        br = 2'b10;
        frames(8);
        want("hold8", 1, 0, 8);
        frame();
        want("hold9", 1, 0, ACC ? 10 : 9);
        frames(11);
        want("hold20", 1, 0, ACC ? 36 : 20);
        want("ch0_indep", 0, 0, 127);
        br = 2'b00; bl = 2'b10;
        frame();
        want("reversal", 1, 0, ACC ? 35 : 19);
        bl = 2'b00;
        frame();

        // Both buttons held, and presses between edges ignored
        for (int i = 0; i < 11; i++) step_once(0, 1'b1);
        want("to10", 0, 0, 10);
        br = 2'b01; bl = 2'b01;
        frames(5);
        want("both_held", 0, 0, 10);
        bl = 2'b00;
        frame();
        want("after_both", 0, 0, 11);
        br = 2'b00;
        frame();
        br = 2'b01;
        tick(); tick();
        br = 2'b00;
        tick();
        want("no_edge_press", 0, 0, 11);

        // Gray mode and mode-change latency
        for (int i = 0; i < 6; i++) step_once(0, 1'b0);
        want("to5", 0, 0, 5);
        mode = 2'b01;
        want("mode_lag", 0, 0, 5);
        tick();
        want("gray5", 0, 0, 7);
        want("gray_ch1", 1, 0, ACC ? 50 : 26);
        for (int i = 0; i < 6; i++) step_once(0, 1'b0);
        want("gray127", 0, 0, 64);
        mode = 2'b11;
        tick();
        want("mode11_bin", 0, 0, 127);
        mode = 2'b00;

        // Strobe held high through reset release, then quadrature tracking 0 -> 3
        reset = 1'b1; strobe = 1'b1; br = 2'b01; bl = 2'b00;
        tick(); tick();
        reset = 1'b0;
        tick();
        want("rel_lag", 0, 0, 0);
        want("rel_mov", 0, 2, 1);
        strobe = 1'b0;
        tick();
        want("rel_edge", 0, 0, 1);
        frames(2);
        want("jump3", 0, 0, 3);
        br = 2'b00;
        mode = 2'b10;
        want("quad_start", 0, 1, 0);
        want("mov_start", 0, 2, 1);
        prev = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            n = 0;
            while ({qa[0], qb[0]} == prev && n < 100) begin
                tick();
                n++;
            end
            if (n >= 100)
                chk($sformatf("quad%0d_timeout", k), n, 0);
            else if (k > 1)
                chk($sformatf("quad%0d_interval", k), n, PD);
            prev = {qa[0], qb[0]};
            want($sformatf("quad%0d", k), 0, 1, (k == 1) ? 1 : (k == 2) ? 3 : 2);
            want($sformatf("mov%0d", k), 0, 2, (k < 3) ? 1 : 0);
        end
        tick(); tick();
        want("quad_dial", 0, 0, 3);
        want("quad_settled", 0, 2, 0);
        want("ch1_quad", 1, 1, 0);
        want("ch1_dial", 1, 0, 0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
